// File: rtl/gba_slot2_bus_master.sv
// -----------------------------------------------------------------------------
// gba_slot2_bus_master
//
// Master for the GBA slot-2 cartridge ROM bus. A command gives a start halfword
// address, a beat count and a direction. The block turns it into ncs/nrd/nwr
// strobes on the multiplexed AD bus. It supports N accesses (n_wait) and
// S accesses (s_wait), flow-controlled write bursts, and an automatic split
// wherever the burst crosses a 128 KiB (16-bit halfword) boundary.
// Every output is a flop, so the strobes are glitch-free.
//
// Ports
//   phi, rst            bus clock (rising edge) / async active-high reset
//   cmd_valid/ready     command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/len  direction, start halfword address, beats minus one
//   cfg_n_wait/s_wait   wait states, captured when the command is accepted
//   wr_data/valid/ready write beat stream (consumed on valid & ready)
//   rd_data/valid       captured read beat; rd_valid is a one-cycle pulse
//   busy                high whenever the engine is not IDLE
//   ncs/nrd/nwr         active-low cartridge select / read / write strobes
//   ad_out/ad_oe/ad_in  AD bus drive value, output enable, sampled value
//   a_hi                upper address lines [ADDR_W-1:16]
//
// ADDR_W must be greater than 16 so that a_hi has at least one bit.
// -----------------------------------------------------------------------------
module gba_slot2_bus_master #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 8,
    parameter int WAIT_W = 3
) (
    input  logic                 phi,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [WAIT_W-1:0]    cfg_n_wait,
    input  logic [WAIT_W-1:0]    cfg_s_wait,
    input  logic [15:0]          wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 ncs,
    output logic                 nrd,
    output logic                 nwr,
    output logic [15:0]          ad_out,
    output logic                 ad_oe,
    input  logic [15:0]          ad_in,
    output logic [ADDR_W-17:0]   a_hi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,   // address phase: ncs low, AD drives addr[15:0]
        S_ACC,    // strobe phase: nrd or nwr low for wait+1 cycles
        S_GAP,    // strobes high between sequential beats, ncs held low
        S_END     // ncs high for one cycle: end of burst or 128 KiB split
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    beat_q, beat_d;      // beats remaining minus one
    logic                write_q, write_d;
    logic [WAIT_W-1:0]   n_wait_q, n_wait_d;
    logic [WAIT_W-1:0]   s_wait_q, s_wait_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;      // ACC cycles left minus one
    logic                done_q, done_d;      // last beat of the burst issued

    // Next values of the registered outputs.
    logic                ncs_d, nrd_d, nwr_d, ad_oe_d;
    logic [15:0]         ad_out_d;
    logic [ADDR_W-17:0]  a_hi_d;
    logic [15:0]         rd_data_d;
    logic                rd_valid_d, wr_ready_d, busy_d, cmd_ready_d;

    logic                wr_take;

    // A write beat can only be taken in ADDR or GAP, which are exactly the
    // states in which the registered wr_ready is high.
    assign wr_take = wr_valid && wr_ready;

    always_comb begin
        // NOTE: every next-value signal starts from its hold value so that no
        // branch of the case below leaves one unassigned and infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        write_d    = write_q;
        n_wait_d   = n_wait_q;
        s_wait_d   = s_wait_q;
        wait_d     = wait_q;
        done_d     = done_q;
        ad_out_d   = ad_out;
        a_hi_d     = a_hi;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d   = cmd_addr;
                    beat_d   = cmd_len;
                    write_d  = cmd_write;
                    n_wait_d = cfg_n_wait;
                    s_wait_d = cfg_s_wait;
                    done_d   = 1'b0;
                    ad_out_d = cmd_addr[15:0];
                    a_hi_d   = cmd_addr[ADDR_W-1:16];
                    state_d  = S_ADDR;
                end
            end

            S_ADDR: begin
                if (!write_q || wr_take) begin
                    if (write_q) begin
                        ad_out_d = wr_data;
                    end
                    wait_d  = n_wait_q;
                    state_d = S_ACC;
                end
            end

            S_ACC: begin
                if (wait_q == '0) begin
                    if (!write_q) begin
                        rd_data_d  = ad_in;
                        rd_valid_d = 1'b1;
                    end
                    addr_d = addr_q + ADDR_W'(1);
                    beat_d = beat_q - LEN_W'(1);
                    done_d = (beat_q == '0);
                    // Crossing a 16-bit boundary needs a fresh N access so
                    // that the cartridge relatches the new upper address.
                    if (beat_q == '0 || addr_q[15:0] == 16'hFFFF) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            S_GAP: begin
                if (!write_q || wr_take) begin
                    if (write_q) begin
                        ad_out_d = wr_data;
                    end
                    wait_d  = s_wait_q;
                    state_d = S_ACC;
                end
            end

            S_END: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    ad_out_d = addr_q[15:0];
                    a_hi_d   = addr_q[ADDR_W-1:16];
                    state_d  = S_ADDR;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // The bus outputs are decoded from the state being entered, so each
        // one changes on the same edge as the state register.
        ncs_d       = !(state_d inside {S_ADDR, S_ACC, S_GAP});
        nrd_d       = !(state_d == S_ACC && !write_d);
        nwr_d       = !(state_d == S_ACC && write_d);
        ad_oe_d     = (state_d == S_ADDR) ||
                      (write_d && (state_d inside {S_ACC, S_GAP}));
        wr_ready_d  = write_d && (state_d inside {S_ADDR, S_GAP});
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge phi or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            beat_q    <= '0;
            write_q   <= 1'b0;
            n_wait_q  <= '0;
            s_wait_q  <= '0;
            wait_q    <= '0;
            done_q    <= 1'b0;
            ncs       <= 1'b1;
            nrd       <= 1'b1;
            nwr       <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            a_hi      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments give every flop the value from
            // before the edge, independent of the order of these statements.
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            write_q   <= write_d;
            n_wait_q  <= n_wait_d;
            s_wait_q  <= s_wait_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
            ncs       <= ncs_d;
            nrd       <= nrd_d;
            nwr       <= nwr_d;
            ad_oe     <= ad_oe_d;
            ad_out    <= ad_out_d;
            a_hi      <= a_hi_d;
            rd_data   <= rd_data_d;
            rd_valid  <= rd_valid_d;
            wr_ready  <= wr_ready_d;
            busy      <= busy_d;
            cmd_ready <= cmd_ready_d;
        end
    end

endmodule

// File: tb/tb_gba_slot2_bus_master.sv
// -----------------------------------------------------------------------------
// tb_gba_slot2_bus_master
//
// Self-checking bench for gba_slot2_bus_master. Each command is expanded into
// a per-cycle timeline. The expansion follows the bus rules: an address
// cycle, wait+1 strobe cycles per beat, one gap between sequential beats, and
// an ncs-high cycle at the end of the burst and at each 128 KiB split. Each
// timeline entry holds the inputs to drive in that cycle and the outputs
// expected in it. One process drives each entry after the rising edge and
// checks the DUT on the falling edge. Strobe run lengths and busy-cycle counts
// are also compared against hand-computed literals after each scenario.
// -----------------------------------------------------------------------------
module tb_gba_slot2_bus_master;

    localparam int AW = 24;
    localparam int LW = 8;
    localparam int WW = 3;

    logic            phi = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [LW-1:0]   cmd_len = '0;
    logic [WW-1:0]   cfg_n_wait = '0;
    logic [WW-1:0]   cfg_s_wait = '0;
    logic [15:0]     wr_data = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [15:0]     rd_data;
    logic            rd_valid;
    logic            busy;
    logic            ncs, nrd, nwr;
    logic [15:0]     ad_out;
    logic            ad_oe;
    logic [15:0]     ad_in = '0;
    logic [AW-17:0]  a_hi;

    gba_slot2_bus_master #(.ADDR_W(AW), .LEN_W(LW), .WAIT_W(WW)) dut (
        .phi(phi), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cfg_n_wait(cfg_n_wait), .cfg_s_wait(cfg_s_wait),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .ncs(ncs), .nrd(nrd), .nwr(nwr),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .a_hi(a_hi)
    );

    always #5 phi = ~phi;

    // One bus cycle: inputs to drive, outputs expected.
    typedef struct {
        logic           cv, cw;
        logic [AW-1:0]  ca;
        logic [LW-1:0]  cl;
        logic [WW-1:0]  cn, cs;
        logic           wv;
        logic [15:0]    wd, ai;
        logic           ncs, nrd, nwr, oe;
        logic [15:0]    ado;
        logic [7:0]     ahi;
        logic           rv;
        logic [15:0]    rd;
        logic           busy, crdy, wrdy;
    } cyc_t;

    cyc_t        tl[$];
    logic [15:0] m_rd    = '0;   // model rd_data as of the end of the timeline
    logic [15:0] last_rd = '0;   // model rd_data as of the cycle just checked
    int          wr_stall[4];    // wr_valid low cycles before each write beat

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int nrd_runs[$];
    int nwr_runs[$];
    int nrd_cnt, nwr_cnt, rv_count, busy_cycles;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_mon();
        nrd_runs.delete();
        nwr_runs.delete();
        nrd_cnt = 0; nwr_cnt = 0; rv_count = 0; busy_cycles = 0;
    endtask

    function automatic cyc_t idle_rec();
        cyc_t r;
        r = '{cv: 1'b0, cw: 1'b0, ca: '0, cl: '0, cn: '0, cs: '0, wv: 1'b0,
              wd: 16'h0, ai: 16'h0, ncs: 1'b1, nrd: 1'b1, nwr: 1'b1, oe: 1'b0,
              ado: 16'h0, ahi: 8'h0, rv: 1'b0, rd: last_rd, busy: 1'b0,
              crdy: 1'b1, wrdy: 1'b0};
        return r;
    endfunction

    // Expand one command into its cycle-by-cycle timeline, starting with the
    // IDLE cycle in which it is accepted.
    task automatic build(input logic w, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input logic [WW-1:0] nw, input logic [WW-1:0] sw,
                         input logic hold, input logic [15:0] dbase);
        cyc_t          base, r;
        logic [AW-1:0] a, seg;
        logic [15:0]   d;
        int            beats, b, wt, ns;
        logic          pend;
        base = '{cv: hold, cw: w, ca: addr, cl: len, cn: nw, cs: sw, wv: 1'b0,
                 wd: 16'h0, ai: 16'h5A5A, ncs: 1'b1, nrd: 1'b1, nwr: 1'b1, oe: 1'b0,
                 ado: 16'h0, ahi: 8'h0, rv: 1'b0, rd: 16'h0, busy: 1'b1,
                 crdy: 1'b0, wrdy: 1'b0};
        a = addr; beats = int'(len) + 1; b = 0; pend = 1'b0;
        r = base; r.cv = 1'b1; r.busy = 1'b0; r.crdy = 1'b1; r.rd = m_rd;
        tl.push_back(r);
        while (b < beats) begin
            seg = a;
            d   = dbase + 16'(b);
            ns  = w ? wr_stall[b] : 0;
            for (int k = 0; k <= ns; k++) begin
                r = base; r.ncs = 1'b0; r.oe = 1'b1; r.ado = a[15:0]; r.ahi = a[23:16];
                r.wrdy = w; r.wv = w && (k == ns); r.wd = r.wv ? d : ~d;
                r.rv = pend; pend = 1'b0; r.rd = m_rd;
                tl.push_back(r);
            end
            wt = int'(nw);
            while (1) begin
                d = dbase + 16'(b);
                for (int k = 0; k <= wt; k++) begin
                    r = base; r.ncs = 1'b0; r.ahi = seg[23:16]; r.rd = m_rd;
                    if (w) begin
                        r.nwr = 1'b0; r.oe = 1'b1; r.ado = d;
                    end else begin
                        r.nrd = 1'b0; r.ai = (k == wt) ? d : ~d;
                    end
                    tl.push_back(r);
                end
                if (!w) begin
                    m_rd = d; pend = 1'b1;
                end
                b++; a = a + 1'b1;
                if (b == beats || a[15:0] == 16'h0) break;
                ns = w ? wr_stall[b] : 0;
                for (int k = 0; k <= ns; k++) begin
                    r = base; r.ncs = 1'b0; r.ahi = seg[23:16]; r.oe = w; r.ado = d;
                    r.wrdy = w; r.wv = w && (k == ns);
                    r.wd = r.wv ? (dbase + 16'(b)) : ~(dbase + 16'(b));
                    r.rv = pend; pend = 1'b0; r.rd = m_rd;
                    tl.push_back(r);
                end
                wt = int'(sw);
            end
            r = base; r.rv = pend; pend = 1'b0; r.rd = m_rd;
            tl.push_back(r);
        end
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic step(input cyc_t r);
        cmd_valid = r.cv; cmd_write = r.cw; cmd_addr = r.ca; cmd_len = r.cl;
        cfg_n_wait = r.cn; cfg_s_wait = r.cs;
        wr_valid = r.wv; wr_data = r.wd; ad_in = r.ai;
        @(negedge phi);
        check("ncs", 32'(ncs), 32'(r.ncs));
        check("nrd", 32'(nrd), 32'(r.nrd));
        check("nwr", 32'(nwr), 32'(r.nwr));
        check("ad_oe", 32'(ad_oe), 32'(r.oe));
        if (r.oe) check("ad_out", 32'(ad_out), 32'(r.ado));
        if (!r.ncs) check("a_hi", 32'(a_hi), 32'(r.ahi));
        check("rd_valid", 32'(rd_valid), 32'(r.rv));
        check("rd_data", 32'(rd_data), 32'(r.rd));
        check("busy", 32'(busy), 32'(r.busy));
        check("cmd_ready", 32'(cmd_ready), 32'(r.crdy));
        check("wr_ready", 32'(wr_ready), 32'(r.wrdy));
        if (nrd === 1'b0) nrd_cnt++;
        else if (nrd_cnt > 0) begin nrd_runs.push_back(nrd_cnt); nrd_cnt = 0; end
        if (nwr === 1'b0) nwr_cnt++;
        else if (nwr_cnt > 0) begin nwr_runs.push_back(nwr_cnt); nwr_cnt = 0; end
        if (rd_valid === 1'b1) rv_count++;
        if (busy === 1'b1) busy_cycles++;
        last_rd = r.rd;
        @(posedge phi);
        #1;
        cyc++;
    endtask

    task automatic run_all();
        while (tl.size() > 0) step(tl.pop_front());
        repeat (2) step(idle_rec());
    endtask

    task automatic check_runs(input string nm, input bit use_wr, input int n,
                              input int e0, input int e1, input int e2, input int e3);
        int e[4];
        int q[$];
        e = '{e0, e1, e2, e3};
        if (use_wr) q = nwr_runs; else q = nrd_runs;
        check({nm, "_pulses"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++)
            check($sformatf("%s_pulse%0d_len", nm, i), 32'(q[i]), 32'(e[i]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_ncs", 32'(ncs), 32'd1);
        check("rst_nrd", 32'(nrd), 32'd1);
        check("rst_nwr", 32'(nwr), 32'd1);
        check("rst_ad_oe", 32'(ad_oe), 32'd0);
        check("rst_ad_out", 32'(ad_out), 32'd0);
        check("rst_a_hi", 32'(a_hi), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge phi);
        @(negedge phi) rst = 1'b0;
        @(posedge phi);
        #1;

        // Single read, n_wait=2, ad_in=0xDA7A.
        clear_mon();
        build(1'b0, 24'h000123, 8'd0, 3'd2, 3'd0, 1'b0, 16'hDA7A);
        run_all();
        check_runs("single_nrd", 1'b0, 1, 3, 0, 0, 0);
        check("single_rv_count", 32'(rv_count), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'hDA7A);
        check("single_busy_cycles", 32'(busy_cycles), 32'd5);

        // Burst read, len=3, n_wait=3, s_wait=1.
        clear_mon();
        build(1'b0, 24'h120040, 8'd3, 3'd3, 3'd1, 1'b0, 16'h4C00);
        run_all();
        check_runs("burst_nrd", 1'b0, 4, 4, 2, 2, 2);
        check("burst_rv_count", 32'(rv_count), 32'd4);
        check("burst_rd_data", 32'(rd_data), 32'h4C03);
        check("burst_busy_cycles", 32'(busy_cycles), 32'd15);

        // Read across the 128 KiB boundary: split into two N accesses.
        clear_mon();
        build(1'b0, 24'h00FFFE, 8'd3, 3'd2, 3'd1, 1'b0, 16'h8800);
        run_all();
        check_runs("wrap_nrd", 1'b0, 4, 3, 2, 3, 2);
        check("wrap_rv_count", 32'(rv_count), 32'd4);
        check("wrap_busy_cycles", 32'(busy_cycles), 32'd16);

        // Write burst, wr_valid low for 3 cycles before beat 2.
        clear_mon();
        wr_stall = '{0, 3, 0, 0};
        build(1'b1, 24'h0300A0, 8'd1, 3'd1, 3'd2, 1'b0, 16'hC0DE);
        run_all();
        check_runs("write_nwr", 1'b1, 2, 2, 3, 0, 0);
        check("write_busy_cycles", 32'(busy_cycles), 32'd11);
        check("write_no_nrd", 32'(nrd_runs.size()), 32'd0);

        // Write at the top of the address space: wraps to address 0.
        clear_mon();
        wr_stall = '{0, 0, 0, 0};
        build(1'b1, 24'hFFFFFF, 8'd1, 3'd0, 3'd0, 1'b0, 16'h1234);
        run_all();
        check_runs("topwrap_nwr", 1'b1, 2, 1, 1, 0, 0);
        check("topwrap_busy_cycles", 32'(busy_cycles), 32'd6);

        // cmd_valid held high across two single-beat reads, zero waits.
        clear_mon();
        build(1'b0, 24'h000010, 8'd0, 3'd0, 3'd0, 1'b1, 16'h0A0A);
        build(1'b0, 24'h000020, 8'd0, 3'd0, 3'd0, 1'b1, 16'h0B0B);
        run_all();
        check_runs("queued_nrd", 1'b0, 2, 1, 1, 0, 0);
        check("queued_rv_count", 32'(rv_count), 32'd2);
        check("queued_rd_data", 32'(rd_data), 32'h0B0B);
        check("queued_busy_cycles", 32'(busy_cycles), 32'd6);

        // Reset during the second ACC cycle of a read burst.
        clear_mon();
        build(1'b0, 24'h000200, 8'd3, 3'd3, 3'd1, 1'b0, 16'h3300);
        repeat (3) step(tl.pop_front());
        check("rstmid_pre_nrd", 32'(nrd), 32'd0);
        rst = 1'b1;
        #1;
        check("rstmid_ncs", 32'(ncs), 32'd1);
        check("rstmid_nrd", 32'(nrd), 32'd1);
        check("rstmid_nwr", 32'(nwr), 32'd1);
        check("rstmid_ad_oe", 32'(ad_oe), 32'd0);
        check("rstmid_rd_valid", 32'(rd_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        tl.delete();
        m_rd = '0;
        last_rd = '0;
        cmd_valid = 1'b0;
        repeat (2) begin
            @(negedge phi);
            check("rstmid_hold_rd_valid", 32'(rd_valid), 32'd0);
            check("rstmid_hold_ncs", 32'(ncs), 32'd1);
        end
        rst = 1'b0;
        @(posedge phi);
        #1;
        check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstmid_rd_data", 32'(rd_data), 32'd0);
        clear_mon();
        build(1'b0, 24'h000456, 8'd0, 3'd1, 3'd0, 1'b0, 16'h7E57);
        run_all();
        check_runs("after_rst_nrd", 1'b0, 1, 2, 0, 0, 0);
        check("after_rst_rd_data", 32'(rd_data), 32'h7E57);
        check("after_rst_busy_cycles", 32'(busy_cycles), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
